// File: rtl/j2_arb_pkg.sv
// rtl/j2_arb_pkg.sv - shared types and defaults for the j2 data-RAM arbiter
//
// Purpose: read-owner and FSM state enums, default starvation bound.
// Used by j2_mem_arbiter and j2_arb_starve_ctr.
package j2_arb_pkg;

  localparam int STARVE_MAX_DEFAULT = 3;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/j2_arb_starve_ctr.sv
// rtl/j2_arb_starve_ctr.sv - saturating host starvation counter
//
// Purpose: counts consecutive cycles a pending host request lost to the CPU.
// Ports:
//   clk_i, reset_i  clock, asynchronous active-high reset
//   clr_i           clear to 0 (has priority over inc_i)
//   inc_i           increment, saturating at MAX
//   at_max_o        count equals MAX (always 1 when MAX == 0)
module j2_arb_starve_ctr #(
  parameter int MAX = 3,
  parameter int CW  = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign at_max_o = (cnt_q == CW'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/j2_mem_arbiter.sv
// rtl/j2_mem_arbiter.sv - CPU/host arbiter in front of the single-port data RAM
//
// Purpose: zero-latency grant between the j2 CPU data port and a host/loader
// port, CPU-priority with bounded host starvation, pipelined read return.
// Optional macro J2_ARB_BOOT_HOLD_EN: start in BOOT with the core held in
// reboot and the host owning the RAM until host_boot_done.
// Ports:
//   clk, reset                              clock, async active-high reset
//   cpu_req/we/addr/wdata -> cpu_gnt/stall  CPU request and grant
//   cpu_rvalid/rdata                        CPU read return (1 cycle later)
//   host_req/we/addr/wdata -> host_gnt      host request and grant
//   host_rvalid/rdata                       host read return (1 cycle later)
//   host_boot_done -> cpu_reboot            boot hold release (macro only)
//   ram_en/we/addr/wdata, ram_rdata         RAM macro interface
module j2_mem_arbiter
  import j2_arb_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ADDR_W     = 13,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [WIDTH-1:0]  cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [WIDTH-1:0]  cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [WIDTH-1:0]  host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [WIDTH-1:0]  host_rdata,
  input  logic              host_boot_done,
  output logic              cpu_reboot,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_wdata,
  input  logic [WIDTH-1:0]  ram_rdata
);

`ifdef J2_ARB_BOOT_HOLD_EN
  localparam arb_state_t ST_RESET = ST_BOOT;
`else
  localparam arb_state_t ST_RESET = ST_RUN;
`endif

  arb_state_t state_q, state_d;
  owner_t     rd_owner_q, rd_owner_d;
  logic       host_at_max;

  j2_arb_starve_ctr #(
    .MAX(STARVE_MAX)
  ) u_starve (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   (host_gnt | ~host_req),
    .inc_i   (host_req & ~host_gnt),
    .at_max_o(host_at_max)
  );

  // Next state and grants. In BOOT the core is frozen in reboot, so only the
  // host can reach the RAM and the CPU is not reported as stalled.
  always_comb begin
    state_d  = state_q;
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    case (state_q)
      ST_BOOT: begin
        host_gnt = host_req;
`ifdef J2_ARB_BOOT_HOLD_EN
        if (host_boot_done) begin
          state_d = ST_RUN;
        end
`endif
      end
      default: begin
        if (cpu_req && host_req) begin
          host_gnt = host_at_max;
          cpu_gnt  = ~host_at_max;
        end else begin
          cpu_gnt  = cpu_req;
          host_gnt = host_req;
        end
      end
    endcase
  end

  assign cpu_stall = cpu_req & ~cpu_gnt & (state_q == ST_RUN);

  // RAM mux; outputs idle at zero so the macro sees a quiet bus.
  always_comb begin
    ram_en     = cpu_gnt | host_gnt;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    rd_owner_d = OWN_NONE;
    if (cpu_gnt) begin
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      if (!cpu_we) rd_owner_d = OWN_CPU;
    end else if (host_gnt) begin
      ram_we    = host_we;
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
      if (!host_we) rd_owner_d = OWN_HOST;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RESET;
      rd_owner_q <= OWN_NONE;
    end else begin
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign cpu_rvalid  = (rd_owner_q == OWN_CPU);
  assign host_rvalid = (rd_owner_q == OWN_HOST);
  assign cpu_rdata   = ram_rdata;
  assign host_rdata  = ram_rdata;

`ifdef J2_ARB_BOOT_HOLD_EN
  logic reboot_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reboot_q <= 1'b1;
    end else begin
      reboot_q <= (state_d == ST_BOOT);
    end
  end

  assign cpu_reboot = reboot_q;
`else
  logic unused_boot_done;

  assign unused_boot_done = host_boot_done;
  assign cpu_reboot       = 1'b0;
`endif

endmodule
